// File: rtl/lane_rx_aligner.sv
// -----------------------------------------------------------------------------
// lane_rx_aligner
//
// Per-lane receive word aligner and keep-alive filter. It sits between one
// transceiver RX lane and that lane's receive clock-crossing FIFO, and runs
// in the lane's rx clock domain.
//
// Operation:
//   HUNT      - counts consecutive words whose 2-bit sync header is valid.
//               After LOCK_COUNT of them the lane is declared locked. An
//               invalid header clears the run, pulses oslip for one cycle
//               and enters SLIP_HOLD.
//   SLIP_HOLD - ignores SLIP_WAIT words while the transceiver shifts its
//               word boundary, then returns to HUNT with a fresh run.
//   LOCKED    - forwards data words (header 01), drops control/keep-alive
//               words (header 10) and counts invalid headers (00/11) per
//               WINDOW-word window. BAD_MAX invalid headers inside one
//               window drop the lane back to HUNT without a slip.
//
// Ports:
//   clock      in   lane rx clock
//   reset      in   asynchronous, active-high reset (release synchronously)
//   idata      in   [0:w-1] raw received word; idata[0:1] is the sync header
//   oslip      out  one-cycle slip request to the transceiver
//   aligned    out  lane locked
//   odata      out  [0:w-1] received word delayed by one cycle
//   ovalid     out  odata holds a forwarded data word
//   slip_count out  [7:0] slips since reset, saturating at 255
//
// All outputs are registered; data path latency is one cycle. There is no
// backpressure: every ovalid cycle must be accepted downstream.
// -----------------------------------------------------------------------------
module lane_rx_aligner #(
    parameter int w          = 128,
    parameter int LOCK_COUNT = 64,
    parameter int SLIP_WAIT  = 32,
    parameter int WINDOW     = 1024,
    parameter int BAD_MAX    = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [0:w-1] idata,
    output logic         oslip,
    output logic         aligned,
    output logic [0:w-1] odata,
    output logic         ovalid,
    output logic [7:0]   slip_count
);

    // Counter widths. Each counter only ever holds values up to its
    // terminal value, which is one less than the parameter it tracks.
    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int HW = $clog2(SLIP_WAIT + 1);
    localparam int WW = $clog2(WINDOW);
    localparam int BW = $clog2(BAD_MAX + 1);

    localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_COUNT - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(SLIP_WAIT - 1);
    localparam logic [WW-1:0] WIN_LAST  = WW'(WINDOW - 1);
    localparam logic [BW-1:0] BAD_LAST  = BW'(BAD_MAX - 1);

    localparam logic [7:0] SLIP_SAT = 8'hFF;

    typedef enum logic [1:0] {
        HUNT      = 2'd0,
        SLIP_HOLD = 2'd1,
        LOCKED    = 2'd2
    } state_t;

    // Sync header classification helpers.
    function automatic logic hdr_is_data(input logic [1:0] hdr_v);
        return (hdr_v == 2'b01);
    endfunction

    function automatic logic hdr_is_valid(input logic [1:0] hdr_v);
        return (hdr_v == 2'b01) || (hdr_v == 2'b10);
    endfunction

    state_t          state;
    state_t          state_next;
    logic [GW-1:0]   good_cnt;
    logic [GW-1:0]   good_next;
    logic [HW-1:0]   hold_cnt;
    logic [HW-1:0]   hold_next;
    logic [WW-1:0]   win_cnt;
    logic [WW-1:0]   win_next;
    logic [BW-1:0]   bad_cnt;
    logic [BW-1:0]   bad_next;
    logic            slip_fire;
    logic            fwd;
    logic [1:0]      hdr;
    logic            hdr_valid;
    logic            hdr_data;

    assign hdr       = idata[0:1];
    assign hdr_valid = hdr_is_valid(hdr);
    assign hdr_data  = hdr_is_data(hdr);

    // Next-state, counter and output-strobe decode for the alignment FSM.
    always_comb begin
        state_next = state;
        good_next  = good_cnt;
        hold_next  = hold_cnt;
        win_next   = win_cnt;
        bad_next   = bad_cnt;
        slip_fire  = 1'b0;
        fwd        = 1'b0;

        case (state)
            HUNT: begin
                if (hdr_valid) begin
                    if (good_cnt == GOOD_LAST) begin
                        // This word completes the run; it is not forwarded.
                        // The monitoring window starts with the next word.
                        state_next = LOCKED;
                        good_next  = {GW{1'b0}};
                        win_next   = {WW{1'b0}};
                        bad_next   = {BW{1'b0}};
                    end else begin
                        good_next = good_cnt + GW'(1);
                    end
                end else begin
                    state_next = SLIP_HOLD;
                    good_next  = {GW{1'b0}};
                    hold_next  = {HW{1'b0}};
                    slip_fire  = 1'b1;
                end
            end

            SLIP_HOLD: begin
                // Words seen here come from an unsettled boundary and are
                // not evaluated at all.
                if (hold_cnt == HOLD_LAST) begin
                    state_next = HUNT;
                    hold_next  = {HW{1'b0}};
                    good_next  = {GW{1'b0}};
                end else begin
                    hold_next = hold_cnt + HW'(1);
                end
            end

            LOCKED: begin
                fwd = hdr_data;
                if (!hdr_valid && (bad_cnt == BAD_LAST)) begin
                    // Loss of lock takes priority over a coincident window
                    // wrap. No slip here: HUNT slips on its own next error.
                    state_next = HUNT;
                    good_next  = {GW{1'b0}};
                    win_next   = {WW{1'b0}};
                    bad_next   = {BW{1'b0}};
                end else begin
                    if (win_cnt == WIN_LAST) begin
                        // The wrap word is the last word of the old window,
                        // so a bad header here does not carry over.
                        win_next = {WW{1'b0}};
                        bad_next = {BW{1'b0}};
                    end else begin
                        win_next = win_cnt + WW'(1);
                        if (!hdr_valid) begin
                            bad_next = bad_cnt + BW'(1);
                        end else begin
                            bad_next = bad_cnt;
                        end
                    end
                end
            end

            default: begin
                state_next = HUNT;
                good_next  = {GW{1'b0}};
                hold_next  = {HW{1'b0}};
                win_next   = {WW{1'b0}};
                bad_next   = {BW{1'b0}};
            end
        endcase
    end

    // FSM state and counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= HUNT;
            good_cnt <= {GW{1'b0}};
            hold_cnt <= {HW{1'b0}};
            win_cnt  <= {WW{1'b0}};
            bad_cnt  <= {BW{1'b0}};
        end else begin
            state    <= state_next;
            good_cnt <= good_next;
            hold_cnt <= hold_next;
            win_cnt  <= win_next;
            bad_cnt  <= bad_next;
        end
    end

    // Registered outputs: one-cycle latency for data, strobes and status.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            oslip      <= 1'b0;
            aligned    <= 1'b0;
            odata      <= {w{1'b0}};
            ovalid     <= 1'b0;
            slip_count <= 8'd0;
        end else begin
            oslip   <= slip_fire;
            aligned <= (state_next == LOCKED);
            odata   <= idata;
            ovalid  <= fwd;
            if (slip_fire && (slip_count != SLIP_SAT)) begin
                slip_count <= slip_count + 8'd1;
            end else begin
                slip_count <= slip_count;
            end
        end
    end

endmodule
